// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared definitions for the instruction queue.
//   LINE_WORDS   - 32-bit words per cache line
//   WORD_BITS    - instruction width
//   IQ_PC_W      - PC width carried in each queue entry
//   iq_entry_t   - one queued instruction with its PC
//   line_word_pc - PC of word idx inside the line whose upper PC bits are line_hi
package inst_queue_pkg;

  localparam int LINE_WORDS = 16;
  localparam int WORD_BITS  = 32;
  localparam int IQ_PC_W    = 64;

  typedef struct packed {
    logic [WORD_BITS-1:0] inst;
    logic [IQ_PC_W-1:0]   pc;
  } iq_entry_t;

  function automatic logic [IQ_PC_W-1:0] line_word_pc(
    input logic [IQ_PC_W-7:0] line_hi,
    input logic [3:0]         idx
  );
    return {line_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/iq_fifo.sv
// iq_fifo: circular instruction buffer, up to ENQ_WIDTH writes and
// DEC_WIDTH reads per cycle.
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_clear     - empties the buffer at the next edge, overriding writes and reads
//   i_wr_cnt    - number of entries of i_wr_data to append (0..ENQ_WIDTH)
//   i_wr_data   - entries to append, element 0 first
//   i_rd_cnt    - number of entries to retire from the head (0..DEC_WIDTH)
//   o_rd_data   - entries at head+0 .. head+DEC_WIDTH-1 (valid only below o_count)
//   o_count     - registered occupancy
// The caller guarantees i_wr_cnt <= DEPTH - o_count and i_rd_cnt <= o_count.
import inst_queue_pkg::*;

module iq_fifo #(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 4,
  parameter int DEC_WIDTH = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clear,
  input  logic [CW-1:0]               i_wr_cnt,
  input  iq_entry_t [ENQ_WIDTH-1:0]   i_wr_data,
  input  logic [CW-1:0]               i_rd_cnt,
  output iq_entry_t [DEC_WIDTH-1:0]   o_rd_data,
  output logic [CW-1:0]               o_count
);

  iq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + i_rd_cnt[AW-1:0];
      r_tail  <= r_tail + i_wr_cnt[AW-1:0];
      r_count <= r_count + i_wr_cnt - i_rd_cnt;
    end
  end

  // Storage needs no reset: entries are only observed below r_count.
  always_ff @(posedge clk) begin
    if (!i_clear) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (CW'(i) < i_wr_cnt) begin
          r_mem[r_tail + AW'(i)] <= i_wr_data[i];
        end
      end
    end
  end

  for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_rd
    assign o_rd_data[i] = r_mem[r_head + AW'(i)];
  end

  assign o_count = r_count;

endmodule

// File: rtl/inst_queue.sv
// inst_queue: buffer between the instruction cache and decode.
// A fetched 64-byte line is held in a one-entry line buffer, split into
// 32-bit instructions starting at the PC's word offset, and moved into an
// instruction FIFO up to ENQ_WIDTH per cycle. Decode sees the DEC_WIDTH
// oldest instructions with their PCs.
//   clk, rst_n        - clock, asynchronous active-low reset
//   icache_valid_i    - line/PC valid from the cache
//   icache_pc_i       - fetch PC of the line (bits [1:0] ignored)
//   icache_data_i     - line data, word k = bits [32k+31:32k]
//   stall_icache_o    - cache must hold its output
//   dec_valid_o       - per-slot valid, slot 0 oldest
//   dec_inst_o        - instruction per slot (zero when slot invalid)
//   dec_pc_o          - PC per slot (zero when slot invalid)
//   dec_ready_i       - decode consumes every valid slot this cycle
//   squash_pipe_i     - flush everything; highest priority
// Optional (macro IQ_PERF_EN):
//   perf_stall_cnt_o  - saturating count of cycles with stall_icache_o && icache_valid_i
//   perf_empty_cnt_o  - saturating count of cycles with empty FIFO && dec_ready_i
//
// Handshakes: a line transfers on a cycle where icache_valid_i is high,
// stall_icache_o is low and squash_pipe_i is low; stall_icache_o acts as an
// inverted ready that never depends on icache_valid_i. Towards decode, every
// slot with dec_valid_o set is consumed on a cycle where dec_ready_i is high.
import inst_queue_pkg::*;

module inst_queue #(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 4,
  parameter int DEC_WIDTH = 2,
  parameter int LINE_BITS = 512,
  parameter int PC_WIDTH  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          icache_valid_i,
  input  logic [PC_WIDTH-1:0]           icache_pc_i,
  input  logic [LINE_BITS-1:0]          icache_data_i,
  output logic                          stall_icache_o,
  output logic [DEC_WIDTH-1:0]          dec_valid_o,
  output logic [DEC_WIDTH*32-1:0]       dec_inst_o,
  output logic [DEC_WIDTH*PC_WIDTH-1:0] dec_pc_o,
  input  logic                          dec_ready_i,
  input  logic                          squash_pipe_i
`ifdef IQ_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt_o,
  output logic [31:0]                   perf_empty_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                    r_lb_valid;
  logic [LINE_BITS-1:0]    r_lb_data;
  logic [PC_WIDTH-7:0]     r_lb_pc_hi;
  logic [3:0]              r_lb_ptr;

  logic [CW-1:0]           w_count;
  logic [CW-1:0]           w_n;
  logic [CW-1:0]           w_pop;
  logic                    w_lb_done;
  logic                    w_stall;
  logic                    w_accept;
  logic [WORD_BITS-1:0]    w_words [LINE_WORDS];
  iq_entry_t [ENQ_WIDTH-1:0] w_wr_data;
  iq_entry_t [DEC_WIDTH-1:0] w_rd_data;
  logic [DEC_WIDTH-1:0]    w_dec_valid;
  logic                    w_unused_pc_lo;

  assign w_unused_pc_lo = ^icache_pc_i[1:0];

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_words
    assign w_words[k] = r_lb_data[WORD_BITS*k +: WORD_BITS];
  end

  // Enqueue size: limited by the enqueue width, the words left in the line
  // and the free space as of the registered count (same-cycle pops do not
  // make room). Squash is deliberately left out so the stall depends only
  // on registered state; the FIFO ignores writes while clearing.
  always_comb begin
    int v_n;
    v_n = 0;
    if (r_lb_valid) begin
      v_n = ENQ_WIDTH;
      if (LINE_WORDS - int'(r_lb_ptr) < v_n) v_n = LINE_WORDS - int'(r_lb_ptr);
      if (DEPTH - int'(w_count) < v_n)       v_n = DEPTH - int'(w_count);
    end
    w_n       = CW'(v_n);
    w_lb_done = r_lb_valid && (int'(r_lb_ptr) + v_n == LINE_WORDS);
  end

  assign w_stall        = r_lb_valid && !w_lb_done;
  assign w_accept       = icache_valid_i && !w_stall && !squash_pipe_i;
  assign stall_icache_o = w_stall;

  for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_wr
    logic [3:0] w_idx;
    assign w_idx        = r_lb_ptr + 4'(i);
    assign w_wr_data[i] = '{inst: w_words[w_idx], pc: line_word_pc(r_lb_pc_hi, w_idx)};
  end

  // A finishing line may be replaced by a new accept in the same cycle,
  // so lines stream back-to-back without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lb_valid <= 1'b0;
      r_lb_data  <= '0;
      r_lb_pc_hi <= '0;
      r_lb_ptr   <= '0;
    end else if (squash_pipe_i) begin
      r_lb_valid <= 1'b0;
      r_lb_ptr   <= '0;
    end else if (w_accept) begin
      r_lb_valid <= 1'b1;
      r_lb_data  <= icache_data_i;
      r_lb_pc_hi <= icache_pc_i[PC_WIDTH-1:6];
      r_lb_ptr   <= icache_pc_i[5:2];
    end else if (r_lb_valid) begin
      r_lb_ptr <= r_lb_ptr + w_n[3:0];
      if (w_lb_done) r_lb_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < DEC_WIDTH; i++) begin : g_dec
    assign w_dec_valid[i]              = (w_count > CW'(i)) && !squash_pipe_i;
    assign dec_inst_o[32*i +: 32]      = w_dec_valid[i] ? w_rd_data[i].inst : '0;
    assign dec_pc_o[PC_WIDTH*i +: PC_WIDTH] = w_dec_valid[i] ? w_rd_data[i].pc : '0;
  end

  assign dec_valid_o = w_dec_valid;
  assign w_pop       = dec_ready_i ? CW'($countones(w_dec_valid)) : '0;

  iq_fifo #(
    .DEPTH     (DEPTH),
    .ENQ_WIDTH (ENQ_WIDTH),
    .DEC_WIDTH (DEC_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (squash_pipe_i),
    .i_wr_cnt  (w_n),
    .i_wr_data (w_wr_data),
    .i_rd_cnt  (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count)
  );

`ifdef IQ_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_empty_cnt;

  // Only reset clears these; squash leaves them running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt <= '0;
      r_perf_empty_cnt <= '0;
    end else begin
      if (w_stall && icache_valid_i && (r_perf_stall_cnt != '1))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if ((w_count == '0) && dec_ready_i && (r_perf_empty_cnt != '1))
        r_perf_empty_cnt <= r_perf_empty_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_perf_stall_cnt;
  assign perf_empty_cnt_o = r_perf_empty_cnt;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: self-checking bench for inst_queue.
// The reference keeps the line buffer and the FIFO as queues of
// {inst, pc} entries and moves words between them with plain arithmetic.
module tb_inst_queue;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          icache_valid_i;
  logic [63:0]   icache_pc_i;
  logic [511:0]  icache_data_i;
  logic          stall_icache_o;
  logic [1:0]    dec_valid_o;
  logic [63:0]   dec_inst_o;
  logic [127:0]  dec_pc_o;
  logic          dec_ready_i;
  logic          squash_pipe_i;
`ifdef IQ_PERF_EN
  logic [31:0]   perf_stall_cnt_o;
  logic [31:0]   perf_empty_cnt_o;
`endif

  inst_queue u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_valid_i (icache_valid_i),
    .icache_pc_i    (icache_pc_i),
    .icache_data_i  (icache_data_i),
    .stall_icache_o (stall_icache_o),
    .dec_valid_o    (dec_valid_o),
    .dec_inst_o     (dec_inst_o),
    .dec_pc_o       (dec_pc_o),
    .dec_ready_i    (dec_ready_i),
    .squash_pipe_i  (squash_pipe_i)
`ifdef IQ_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_empty_cnt_o (perf_empty_cnt_o)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  logic [95:0] exp_q[$];   // expected FIFO contents, oldest first
  logic [95:0] lb_q[$];    // words still waiting in the line buffer
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit m_acc;
  int stall_seen, pops, acc_cyc, first_valid;
  longint m_perf_stall, m_perf_empty;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic present_line(input logic [63:0] pc, input bit ramp);
    icache_pc_i = pc;
    for (int k = 0; k < 16; k++)
      icache_data_i[32*k +: 32] = ramp ? 32'h100 + 32'(k) : $urandom;
    icache_valid_i = 1'b1;
  endtask

  // Fills the reference line buffer with the words of the presented line.
  task automatic load_line();
    logic [63:0] base;
    base = icache_pc_i & ~64'h3F;
    lb_q.delete();
    for (int k = int'(icache_pc_i[5:2]); k < 16; k++)
      lb_q.push_back({icache_data_i[32*k +: 32], base + 64'(k * 4)});
  endtask

  // One clock cycle: check outputs at the falling edge, advance the
  // reference, then step past the rising edge.
  task automatic cycle();
    int cnt, lbs, n, nv;
    bit exp_stall;
    logic [1:0] exp_valid;
    @(negedge clk);
    cnt = exp_q.size();
    lbs = lb_q.size();
    n = 0;
    if (lbs > 0) begin
      n = 4;
      if (lbs < n) n = lbs;
      if (16 - cnt < n) n = 16 - cnt;
    end
    exp_stall = (lbs > 0) && (n != lbs);
    chk("stall", stall_icache_o, exp_stall);
    exp_valid = '0;
    nv = 0;
    for (int i = 0; i < 2; i++)
      if (i < cnt && !squash_pipe_i) begin exp_valid[i] = 1'b1; nv++; end
    chk("dec_valid", dec_valid_o, exp_valid);
    for (int i = 0; i < 2; i++) begin
      if (exp_valid[i]) begin
        chk("slot_inst", dec_inst_o[32*i +: 32], exp_q[i][95:64]);
        chk("slot_pc", dec_pc_o[64*i +: 64], exp_q[i][63:0]);
      end
    end
`ifdef IQ_PERF_EN
    chk("perf_stall_run", perf_stall_cnt_o, m_perf_stall);
    chk("perf_empty_run", perf_empty_cnt_o, m_perf_empty);
`endif
    if (stall_icache_o) stall_seen++;
    if (dec_ready_i) pops += $countones(dec_valid_o);
    if (dec_valid_o[0] && first_valid < 0) first_valid = cyc;
    m_acc = icache_valid_i && !exp_stall && !squash_pipe_i;
    if (m_acc && acc_cyc < 0) acc_cyc = cyc;
    if (exp_stall && icache_valid_i) m_perf_stall++;
    if (cnt == 0 && dec_ready_i) m_perf_empty++;
    if (squash_pipe_i) begin
      exp_q.delete();
      lb_q.delete();
    end else begin
      if (dec_ready_i) repeat (nv) void'(exp_q.pop_front());
      repeat (n) exp_q.push_back(lb_q.pop_front());
      if (m_acc) load_line();
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag, input bit rnd_ready);
    int t;
    t = 0;
    m_acc = 1'b0;
    while (!m_acc && t < 200) begin
      if (rnd_ready) dec_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
      t++;
    end
    n_checks++;
    assert (m_acc) else begin
      n_fail++;
      $error("FAIL %s_accept_timeout obs=0 exp=1", tag);
    end
    icache_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    icache_valid_i = 1'b0;
    icache_pc_i = '0;
    icache_data_i = '0;
    dec_ready_i = 1'b0;
    squash_pipe_i = 1'b0;
    exp_q.delete();
    lb_q.delete();
    m_perf_stall = 0;
    m_perf_empty = 0;
    #1;
    chk("rst_dec_valid", dec_valid_o, 2'b00);
    chk("rst_stall", stall_icache_o, 1'b0);
    chk("rst_dec_inst", dec_inst_o, 64'h0);
    chk("rst_dec_pc", dec_pc_o, 128'h0);
`ifdef IQ_PERF_EN
    chk("rst_perf_stall", perf_stall_cnt_o, 32'h0);
    chk("rst_perf_empty", perf_empty_cnt_o, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    do_reset();

    // Basic line from offset 0 with decode always ready.
    dec_ready_i = 1'b1;
    stall_seen = 0; pops = 0; acc_cyc = -1; first_valid = -1;
    present_line(64'h8000_0000, 1'b1);
    wait_accept("basic", 1'b0);
    repeat (14) cycle();
    chk("basic_latency", 32'(first_valid - acc_cyc), 32'd2);
    chk("basic_stall_cycles", 32'(stall_seen), 32'd3);
    chk("basic_count", 32'(pops), 32'd16);

    // Line fetched at word offset 14: two instructions, no stall.
    stall_seen = 0; pops = 0;
    present_line(64'h8000_0038, 1'b0);
    wait_accept("offset", 1'b0);
    repeat (6) cycle();
    chk("offset_stall_cycles", 32'(stall_seen), 32'd0);
    chk("offset_count", 32'(pops), 32'd2);

    // Backpressure: two back-to-back lines with decode stalled.
    dec_ready_i = 1'b0;
    present_line(64'h1000, 1'b0);
    wait_accept("bp_a", 1'b0);
    present_line(64'h1040, 1'b0);
    wait_accept("bp_b", 1'b0);
    repeat (4) cycle();
    chk("bp_stall_held", stall_icache_o, 1'b1);
    chk("bp_full_slots", dec_valid_o, 2'b11);
    dec_ready_i = 1'b1;
    pops = 0;
    repeat (24) cycle();
    chk("bp_drained", 32'(pops), 32'd32);

    // Squash with 7 queued and a line held in the buffer.
    dec_ready_i = 1'b0;
    present_line(64'h2024, 1'b0);
    wait_accept("sq_a", 1'b0);
    present_line(64'h2040, 1'b0);
    wait_accept("sq_b", 1'b0);
    present_line(64'h3000, 1'b0);
    squash_pipe_i = 1'b1;
    cycle();
    squash_pipe_i = 1'b0;
    dec_ready_i = 1'b1;
    present_line(64'h4000, 1'b0);
    c0 = cyc;
    wait_accept("sq_resume", 1'b0);
    chk("sq_resume_cycles", 32'(cyc - c0), 32'd1);
    repeat (14) cycle();

    // Reset with 10 instructions queued.
    dec_ready_i = 1'b0;
    present_line(64'h5018, 1'b0);
    wait_accept("rst_mid", 1'b0);
    repeat (3) cycle();
    chk("pre_rst_slots", dec_valid_o, 2'b11);
    do_reset();

    // Randomized lines, decode readiness and occasional squashes.
    for (int l = 0; l < 25; l++) begin
      present_line({$urandom, $urandom} & ~64'h3, 1'b0);
      wait_accept("rnd", 1'b1);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        dec_ready_i = $urandom_range(0, 1) != 0;
        squash_pipe_i = ($urandom_range(0, 11) == 0);
        cycle();
        squash_pipe_i = 1'b0;
      end
    end
    dec_ready_i = 1'b1;
    repeat (40) cycle();
    chk("rnd_drained", dec_valid_o, 2'b00);

`ifdef IQ_PERF_EN
    // 5 stalled cycles with valid input, then 3 empty cycles with ready.
    do_reset();
    present_line(64'h0, 1'b0);
    wait_accept("pf_a", 1'b0);
    present_line(64'h40, 1'b0);
    wait_accept("pf_b", 1'b0);
    present_line(64'h80, 1'b0);
    repeat (2) cycle();
    icache_valid_i = 1'b0;
    squash_pipe_i = 1'b1;
    cycle();
    squash_pipe_i = 1'b0;
    dec_ready_i = 1'b1;
    repeat (3) cycle();
    dec_ready_i = 1'b0;
    @(negedge clk);
    chk("perf_stall", perf_stall_cnt_o, 32'd5);
    chk("perf_empty", perf_empty_cnt_o, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Sits between the instruction cache and decode.
- Accepts one 64-byte fetched line plus its fetch PC per handshake and holds it in a one-entry line buffer.
- Splits the line into 32-bit instructions, starting at the PC's word offset, and streams them into an instruction FIFO, up to ENQ_WIDTH per cycle.
- Presents up to DEC_WIDTH oldest instructions, each with its PC, to decode. Back-pressures the cache via a stall signal and flushes fully on pipeline squash.

Parameters:
- DEPTH, 16, FIFO entries (instruction + PC); power of 2, minimum 8.
- ENQ_WIDTH, 4, max instructions moved from line buffer to FIFO per cycle.
- DEC_WIDTH, 2, instruction slots presented to decode.
- LINE_BITS, 512, cache line width; 16 words.
- PC_WIDTH, 64, PC width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icache_valid_i  in  1  line and PC valid from the cache
- icache_pc_i  in  PC_WIDTH  fetch PC of the line
- icache_data_i  in  LINE_BITS  line data; word k = bits [32k+31:32k]
- stall_icache_o  out  1  cache must hold its output
- dec_valid_o  out  DEC_WIDTH  per-slot valid; slot 0 is oldest
- dec_inst_o  out  DEC_WIDTH*32  instruction per slot
- dec_pc_o  out  DEC_WIDTH*PC_WIDTH  PC per slot
- dec_ready_i  in  1  decode consumes all valid slots this cycle
- squash_pipe_i  in  1  flush from the backend

Behaviour:
- Reset (async, rst_n low): lb_valid=0; FIFO head, tail and count = 0; stall_icache_o=0; dec_valid_o=0.
- Accept condition: accept = icache_valid_i && !stall_icache_o && !squash_pipe_i.
- On accept:
  - Line buffer latches data and pc[PC_WIDTH-1:6].
  - lb_ptr = pc[5:2].
  - pc[1:0] is ignored; only 32-bit instructions are supported.
- Enqueue count per cycle: n = min(ENQ_WIDTH, 16-lb_ptr, DEPTH-count). count is the registered value; same-cycle pops do not free space.
- Enqueue action:
  - Words lb_ptr..lb_ptr+n-1 are written at tail..tail+n-1, modulo DEPTH.
  - Each word gets PC = {line_pc_hi, word_idx[3:0], 2'b00}.
  - lb_ptr advances by n.
- Line done: lb_done = lb_valid && (lb_ptr+n == 16). lb_valid clears on lb_done unless a new accept happens in the same cycle, which refills the buffer back-to-back.
- Stall: stall_icache_o = lb_valid && !lb_done. It is combinational from registered state plus the FIFO count.
- Decode outputs:
  - Slot i is valid when i < count and !squash_pipe_i.
  - Slot i shows entry (head+i) mod DEPTH.
  - Outputs are combinational from registered storage.
- Dequeue: pop = dec_ready_i ? popcount(dec_valid_o) : 0. Head advances by pop.
- Count update: count_next = count + n - pop. Simultaneous enqueue and dequeue is supported.
- Latency: a line accepted at edge T appears in the line buffer in cycle T+1. Its first instruction is valid at the decode outputs in cycle T+2.
- Full FIFO: count = DEPTH gives n = 0; the line buffer holds and stall stays high.
- Empty FIFO: dec_valid_o = 0.
- Wrap-around: head and tail are log2(DEPTH)-bit counters and wrap naturally. count is log2(DEPTH)+1 bits.
- Partial line: PC offset 0x3C produces 1 instruction; offset 0 produces 16.
- Squash:
  - Next edge: lb_valid, head, tail, count and lb_ptr = 0.
  - Input in the squash cycle is not accepted.
  - No enqueue or dequeue takes effect in the squash cycle.
  - Squash has priority over every other event.
- Reset mid-operation discards all contents immediately, as with squash.

Optional Feature:
- IQ_PERF_EN defined:
  - Adds output perf_stall_cnt_o [31:0], counting cycles with stall_icache_o=1 && icache_valid_i=1.
  - Adds output perf_empty_cnt_o [31:0], counting cycles with count=0 && dec_ready_i=1.
  - Both counters saturate at 0xFFFFFFFF, reset to 0, and are not cleared by squash.
- IQ_PERF_EN undefined: the ports and counters do not exist.

Decomposition:
- Shared package holds:
  - LINE_WORDS=16 and WORD_BITS=32.
  - Typedef iq_entry_t {inst[31:0], pc[PC_WIDTH-1:0]}.
  - Helper function line_word_pc(line_hi, idx).
- One sub-module, iq_fifo: a multi-write (ENQ_WIDTH), multi-read (DEC_WIDTH) circular buffer exposing count.
- Line buffer, enqueue sizing and stall logic live in inst_queue.

Test Plan:
- Basic line: pc=0x8000_0000, data words 0..15 = 0x100+k, dec_ready=1.
  - First slot valid 2 cycles after accept: slot0 inst 0x100 pc 0x8000_0000, slot1 inst 0x101 pc 0x8000_0004.
  - All 16 instructions in order.
  - Stall high for 3 cycles.
- Offset start: pc=0x8000_0038.
  - Exactly 2 instructions emitted: words 14 and 15, PCs 0x..38 and 0x..3C.
  - Stall never asserted.
- Backpressure: dec_ready=0, two back-to-back lines at pc=0x1000 and 0x1040.
  - FIFO fills to 16 (all of the first line); the second line is accepted and held in the line buffer.
  - stall_icache_o stays high.
  - Releasing ready drains 32 instructions in order across the wrap-around.
- Squash mid-stream: squash_pipe_i asserted while count=7 and lb_valid=1.
  - Same cycle: dec_valid_o=0.
  - Next cycle: count=0, stall=0.
  - A line presented the next cycle is accepted normally.
- Reset mid-operation: rst_n pulsed low while count=10.
  - All outputs 0 immediately.
  - After release, operation resumes from empty.
- IQ_PERF_EN: 5 stalled cycles with valid input, then 3 empty cycles with ready=1.
  - perf_stall_cnt_o=5, perf_empty_cnt_o=3.
